// File: rtl/ddr3_mig_line_adapter.sv
// DDR3 line adapter: splits 256-bit cache line requests into two
// 128-bit MIG UI transactions and reassembles read data.
module ddr3_mig_line_adapter #(
  parameter int APP_ADDR_WIDTH  = 28,
  parameter int APP_DATA_WIDTH  = 128,
  parameter int LINE_ADDR_WIDTH = 29
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LINE_ADDR_WIDTH-1:0]  ctrl_addr_i,
  input  logic [2*APP_DATA_WIDTH-1:0] ctrl_data_i,
  output logic [2*APP_DATA_WIDTH-1:0] ctrl_data_o,
  input  logic                        ctrl_we_i,
  input  logic                        ctrl_rd_i,
  output logic                        ctrl_ack_o,
  input  logic                        init_calib_complete,
  output logic [APP_ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  input  logic                        app_rdy,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  input  logic                        app_rd_data_valid
);

  localparam int D = APP_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_CALIB,
    S_INIT_ACK,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ACK
  } state_t;

  state_t state, state_nx;

  logic [1:0]   cmd_cnt;
  logic [1:0]   dat_cnt;
  logic [1:0]   beat_cnt;
  logic [D-1:0] wdata_hi;
  logic         cmd_acc;
  logic         dat_acc;
  logic         unused_addr;

  assign cmd_acc      = app_en && app_rdy;
  assign dat_acc      = app_wdf_wren && app_wdf_rdy;
  assign app_wdf_mask = '0;
  assign unused_addr  = ^ctrl_addr_i[4:0];

  always_ff @(posedge clk) begin
    if (!rst) state <= S_CALIB;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CALIB:
        if (init_calib_complete) state_nx = S_INIT_ACK;
      S_INIT_ACK:
        state_nx = S_IDLE;
      S_IDLE:
        if (ctrl_we_i)      state_nx = S_WRITE;
        else if (ctrl_rd_i) state_nx = S_READ;
      S_WRITE:
        if (cmd_cnt == 2'd2 && dat_cnt == 2'd2)
          state_nx = S_ACK;
      S_READ:
        if (cmd_cnt == 2'd2 && beat_cnt == 2'd2)
          state_nx = S_ACK;
      S_ACK:
        state_nx = S_IDLE;
      default:
        state_nx = S_CALIB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_ack_o   <= 1'b0;
      ctrl_data_o  <= '0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
      wdata_hi     <= '0;
      cmd_cnt      <= 2'd0;
      dat_cnt      <= 2'd0;
      beat_cnt     <= 2'd0;
    end else begin
      ctrl_ack_o <= (state == S_INIT_ACK) || (state == S_ACK);
      unique case (state)
        S_IDLE: begin
          if (ctrl_we_i || ctrl_rd_i) begin
            app_en       <= 1'b1;
            app_cmd      <= ctrl_we_i ? 3'b000 : 3'b001;
            app_addr     <= {ctrl_addr_i[LINE_ADDR_WIDTH-1:5], 4'b0000};
            app_wdf_wren <= ctrl_we_i;
            app_wdf_end  <= ctrl_we_i;
            cmd_cnt      <= 2'd0;
            dat_cnt      <= 2'd0;
            beat_cnt     <= 2'd0;
          end
          if (ctrl_we_i) begin
            app_wdf_data <= ctrl_data_i[D-1:0];
            wdata_hi     <= ctrl_data_i[2*D-1:D];
          end
        end
        S_WRITE, S_READ: begin
          // command and data paths advance independently
          if (cmd_acc) begin
            cmd_cnt     <= cmd_cnt + 2'd1;
            app_addr[3] <= 1'b1;
            app_en      <= (cmd_cnt == 2'd0);
          end
          if (dat_acc) begin
            dat_cnt      <= dat_cnt + 2'd1;
            app_wdf_data <= wdata_hi;
            app_wdf_wren <= (dat_cnt == 2'd0);
            app_wdf_end  <= (dat_cnt == 2'd0);
          end
          if (state == S_READ && app_rd_data_valid
              && beat_cnt != 2'd2) begin
            if (beat_cnt == 2'd0) ctrl_data_o[D-1:0]   <= app_rd_data;
            else                  ctrl_data_o[2*D-1:D] <= app_rd_data;
            beat_cnt <= beat_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ddr3_mig_line_adapter.md
Name: ddr3_mig_line_adapter

Overview:
- Downstream stage of the DDR3 line cache controller. Converts its 256-bit line read/write handshake (ctrl_* port group) into Xilinx MIG user-interface (UI) commands.
- Each 256-bit line maps to two 128-bit BL8 UI transactions. Write data is split into lower and upper halves; read data is reassembled.
- After calibration completes, issues the single acknowledge pulse that releases the cache controller from its init state.

Parameters:
- APP_ADDR_WIDTH, 28: width of app_addr, in 16-bit DDR word units.
- APP_DATA_WIDTH, 128: UI data beat width. Fixed at 128; the line is always 2 beats.
- LINE_ADDR_WIDTH, 29: byte address width of ctrl_addr_i.

Ports:
- clk  in  1  system clock; also the MIG ui_clk domain.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- ctrl_addr_i  in  29  line byte address; bits [4:0] ignored.
- ctrl_data_i  in  256  line write data.
- ctrl_data_o  out  256  line read data.
- ctrl_we_i  in  1  line write request, held until ack.
- ctrl_rd_i  in  1  line read request, held until ack.
- ctrl_ack_o  out  1  one-cycle completion pulse.
- init_calib_complete  in  1  MIG calibration done.
- app_addr  out  APP_ADDR_WIDTH  UI command address.
- app_cmd  out  3  UI command: 3'b000 = write, 3'b001 = read.
- app_en  out  1  UI command valid.
- app_rdy  in  1  UI command ready.
- app_wdf_data  out  128  UI write data.
- app_wdf_mask  out  16  UI byte mask; constant 0.
- app_wdf_wren  out  1  UI write data valid.
- app_wdf_end  out  1  last beat of burst; equals app_wdf_wren.
- app_wdf_rdy  in  1  UI write FIFO ready.
- app_rd_data  in  128  UI read data.
- app_rd_data_valid  in  1  UI read data valid.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state = S_CALIB.
  - ctrl_ack_o, app_en, app_wdf_wren, app_wdf_end = 0.
  - app_cmd, app_addr, app_wdf_data, ctrl_data_o = 0.
  - Internal beat counters and latches = 0.
  - Reset mid-transaction abandons it with no ack.
- All outputs are registered. Handshakes:
  - UI command is accepted on an edge where app_en && app_rdy. app_en, app_cmd and app_addr hold stable until accepted.
  - UI data beat is accepted on an edge where app_wdf_wren && app_wdf_rdy. app_wdf_data holds stable until accepted.
- Address mapping: half h (0 = lower 128 bits, 1 = upper) uses app_addr = {ctrl_addr_i[28:5], h, 3'b000}.
- States:
  - S_CALIB: wait for init_calib_complete==1, then go to S_INIT_ACK.
  - S_INIT_ACK: ctrl_ack_o=1 for exactly one cycle, then go to S_IDLE. Issued once per reset, irrespective of ctrl_rd_i/ctrl_we_i.
  - S_IDLE: on ctrl_we_i, latch address and data and go to S_WRITE. Otherwise on ctrl_rd_i, latch address and go to S_READ. ctrl_we_i has priority when both are high.
  - S_WRITE: command path and data path run independently, each counting to 2.
    - Commands issue half 0 then half 1.
    - Data beats send ctrl_data_i[127:0] then [255:128].
    - Data may lead or trail commands.
    - When both counts reach 2, go to S_ACK.
  - S_READ: issue read commands for half 0 then half 1.
    - Capture app_rd_data beats in arrival order: first into ctrl_data_o[127:0], second into [255:128].
    - Beats may arrive before the second command is accepted.
    - After the second beat is captured, go to S_ACK.
  - S_ACK: ctrl_ack_o=1 for one cycle, then S_IDLE. A request still high in S_IDLE on the following cycle is treated as a new request.
- Timing:
  - Best-case write: ack 4 cycles after request sampled with app_rdy=app_wdf_rdy=1.
  - Read: ack 2 cycles after the edge capturing the second beat.
- ctrl_data_o holds its value until the next read's first beat is captured. A write leaves it unchanged.
- app_rd_data_valid outside S_READ is ignored, including stale beats after reset.
- Beats beyond 2 in S_READ are ignored.
- init_calib_complete falling after S_CALIB is ignored.
- Request inputs are sampled only in S_IDLE. Changes during a transaction are ignored.

Test Plan:
- Calibration: rst released, init_calib_complete rises at cycle 20 -> exactly one ctrl_ack_o pulse; no app_en or app_wdf_wren ever asserted.
- Unstalled write: write with ctrl_addr_i=29'h0001_2340, ctrl_data_i={128'hB…, 128'hA…}, app_rdy=app_wdf_rdy=1 ->
  - writes to app_addr 28'h0009_1A0 then 28'h0009_1A8;
  - data beats A then B, app_wdf_end high on each;
  - single ack.
- Stalled write: as above with app_rdy low 5 cycles and app_wdf_rdy low on alternate cycles -> app_en, app_addr and data held stable while stalled; 2 commands and 2 beats exactly; one ack.
- Read: read at 29'h0000_0020, model returns 128'h1111… then 128'h2222… after 10 cycles -> ctrl_data_o = {2222…, 1111…} when ack asserts; value held through a following write.
- Reset mid-read: reset asserted after first read command accepted; model then returns 2 beats -> no ack; ctrl_data_o = 0; calibration ack repeats after release.
- Priority: ctrl_we_i=ctrl_rd_i=1 in S_IDLE -> write commands (app_cmd=0) issued first; after ack, held ctrl_rd_i starts a read.
